jtframe_tdm_mixer: RTL and testbench

Time-multiplexed N-channel audio mixer with per-channel 4.4 fixed-point gain, saturation and clip/overrun reporting. One shared multiplier accumulates all channels sequentially after each sample strobe, so channel count scales without adding multipliers. It sits between the sound-chip outputs and the core's audio DAC/filter stage, and replaces fixed four-channel parallel mixers in new cores.

---
 rtl/jtframe_mixer_pkg.sv | 19 +
 rtl/jtframe_mixer_sat.sv | 34 +++
 rtl/jtframe_tdm_mixer.sv | 112 +++++++++++
 tb/tb_jtframe_tdm_mixer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_mixer_pkg.sv
// rtl/jtframe_mixer_pkg.sv - shared constants, state encoding and helpers for the TDM mixer
package jtframe_mixer_pkg;

  localparam int GAIN_FRAC = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/jtframe_mixer_sat.sv
// rtl/jtframe_mixer_sat.sv - combinational signed clamp from IW bits to WOUT bits with clip flag
module jtframe_mixer_sat #(
  parameter int IW   = 25,
  parameter int WOUT = 20
) (
  input  logic [IW-1:0]   din,
  output logic [WOUT-1:0] dout,
  output logic            clip
);

  // Compare in a width that holds both ranges, so IW < WOUT also works
  localparam int MW = ((IW > WOUT) ? IW : WOUT) + 1;

  logic signed [MW-1:0] dx;
  logic signed [MW-1:0] maxv;
  logic signed [MW-1:0] minv;

  assign dx   = {{(MW-IW){din[IW-1]}}, din};
  assign maxv = {{(MW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  assign minv = {{(MW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

  always_comb begin
    dout = dx[WOUT-1:0];
    clip = 1'b0;
    if (dx > maxv) begin
      dout = maxv[WOUT-1:0];
      clip = 1'b1;
    end else if (dx < minv) begin
      dout = minv[WOUT-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_tdm_mixer.sv
// rtl/jtframe_tdm_mixer.sv - time-multiplexed N-channel mixer, 4.4 gains, one shared multiplier
import jtframe_mixer_pkg::*;

module jtframe_tdm_mixer #(
  parameter int CH   = 4,
  parameter int W    = 16,
  parameter int WOUT = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [CH*W-1:0]   ch,
  input  logic [CH*8-1:0]   gain,
  output logic [WOUT-1:0]   mixed,
  output logic              valid,
  output logic              clip,
  output logic              overrun
);

  localparam int ACCW = W + 9 + clog2(CH);
  localparam int SHW  = ACCW - GAIN_FRAC;
  localparam int IDXW = (clog2(CH) > 0) ? clog2(CH) : 1;

  mix_state_t state, state_nx;

  logic signed [W-1:0]    ch_r   [CH];
  logic        [7:0]      gain_r [CH];
  logic        [IDXW-1:0] idx;
  logic signed [ACCW-1:0] acc;

  logic signed [W-1:0]    ch_sel;
  logic signed [8:0]      gain_sel;
  logic signed [W+8:0]    prod;
  logic signed [SHW-1:0]  shr;
  logic        [WOUT-1:0] sat_out;
  logic                   sat_clip;
  logic                   last;

  assign ch_sel   = ch_r[idx];
  assign gain_sel = {1'b0, gain_r[idx]};
  assign prod     = gain_sel * ch_sel;
  assign last     = (idx == IDXW'(CH-1));
  assign shr      = SHW'(acc >>> GAIN_FRAC);

  jtframe_mixer_sat #(
    .IW   (SHW),
    .WOUT (WOUT)
  ) u_sat (
    .din  (shr),
    .dout (sat_out),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cen) state_nx = ST_ACC;
      ST_ACC:  if (last) state_nx = ST_OUT;
      ST_OUT:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Snapshot isolates the running pass from input changes
  always_ff @(posedge clk) begin
    if (!rst && state == ST_IDLE && cen) begin
      for (int i = 0; i < CH; i++) begin
        ch_r[i]   <= ch[i*W +: W];
        gain_r[i] <= gain[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      idx     <= '0;
      mixed   <= '0;
      valid   <= 1'b0;
      clip    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cen) begin
            acc <= '0;
            idx <= '0;
          end
        end
        ST_ACC: begin
          acc <= acc + ACCW'(prod);
          idx <= idx + IDXW'(1);
          if (cen) overrun <= 1'b1;
        end
        ST_OUT: begin
          mixed <= sat_out;
          clip  <= sat_clip;
          valid <= 1'b1;
          if (cen) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_tdm_mixer.sv
// tb/tb_jtframe_tdm_mixer.sv - scoreboard bench for jtframe_tdm_mixer with a sum-of-products reference model
module tb_jtframe_tdm_mixer;

  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int WOUT = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cen = 1'b0;
  logic [CH*W-1:0]   ch_bus = '0;
  logic [CH*8-1:0]   gain_bus = '0;
  logic [WOUT-1:0]   mixed;
  logic              valid;
  logic              clip;
  logic              overrun;

  jtframe_tdm_mixer #(.CH(CH), .W(W), .WOUT(WOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .ch      (ch_bus),
    .gain    (gain_bus),
    .mixed   (mixed),
    .valid   (valid),
    .clip    (clip),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    bit     clp;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     next_free = 0;
  bit     exp_overrun = 1'b0;
  bit     mon_en = 1'b0;
  longint hold_m = 0;
  bit     hold_c = 1'b0;
  int     chv [CH];
  int     gv  [CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Expected mix: floor(sum(gain*ch) / 16), clamped to the output range
  task automatic model(output longint v, output bit c);
    longint s, qt, hi, lo;
    s = 0;
    for (int i = 0; i < CH; i++) s += longint'(gv[i]) * longint'(chv[i]);
    qt = s / 16;
    if ((s % 16) != 0 && s < 0) qt = qt - 1;
    hi = (longint'(1) << (WOUT-1)) - 1;
    lo = -(longint'(1) << (WOUT-1));
    c = 1'b0;
    v = qt;
    if (qt > hi) begin v = hi; c = 1'b1; end
    if (qt < lo) begin v = lo; c = 1'b1; end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < CH; i++) begin
      ch_bus[i*W +: W]   = W'(chv[i]);
      gain_bus[i*8 +: 8] = 8'(gv[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue();
    exp_t e;
    int   en;
    drive_inputs();
    cen = 1'b1;
    en  = cyc + 1;
    if (en >= next_free) begin
      model(e.val, e.clp);
      e.cyc = en + CH + 1;
      q.push_back(e);
      next_free = en + CH + 2;
    end else begin
      exp_overrun = 1'b1;
    end
    step(1);
    cen = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    hold_m = 0;
    hold_c = 1'b0;
    next_free = 0;
    exp_overrun = 1'b0;
    q.delete();
  endtask

  task automatic set_all(input int cv, input int g);
    for (int i = 0; i < CH; i++) begin
      chv[i] = cv;
      gv[i]  = g;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("valid_cycle", cyc, e.cyc);
          hold_m = e.val;
          hold_c = e.clp;
        end
      end
      check("mixed", longint'($signed(mixed)), hold_m);
      check("clip", longint'(clip), longint'(hold_c));
    end
  end

  initial begin
    set_all(0, 0);
    drive_inputs();
    step(3);
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_mixed", longint'(mixed), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_clip", longint'(clip), 0);
    check("rst_overrun", longint'(overrun), 0);

    set_all(0, 0);
    chv[0] = 1000; gv[0] = 16;
    issue(); step(CH + 3);

    set_all(32767, 255);
    issue(); step(CH + 3);

    set_all(-32768, 255);
    issue(); step(CH + 3);

    set_all(0, 0);
    chv[0] = -3; gv[0] = 8;
    issue(); step(CH + 3);

    // Snapshot: inputs change right after the strobe edge
    set_all(1234, 32);
    issue();
    set_all(-7777, 200);
    drive_inputs();
    step(CH + 3);
    check("no_overrun_yet", longint'(overrun), 0);

    // Back-to-back strobes at the minimum spacing
    set_all(500, 16);
    issue(); step(CH);
    set_all(-500, 48);
    issue(); step(CH + 3);
    check("min_spacing_overrun", longint'(overrun), longint'(exp_overrun));

    set_all(100, 16);
    issue(); step(1);
    set_all(200, 16);
    issue(); step(CH + 3);
    check("overrun_set", longint'(overrun), 1);
    step(5);
    check("overrun_sticky", longint'(overrun), longint'(exp_overrun));

    set_all(4000, 64);
    issue(); step(1);
    do_reset();
    check("midrst_mixed", longint'(mixed), 0);
    check("midrst_clip", longint'(clip), 0);
    check("midrst_overrun", longint'(overrun), 0);
    step(CH + 3);
    check("midrst_valid", longint'(valid), 0);

    set_all(0, 0);
    chv[1] = -2000; gv[1] = 40;
    issue(); step(CH + 3);

    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < CH; i++) begin
        case ($urandom_range(0, 3))
          0: chv[i] = 32767;
          1: chv[i] = -32768;
          default: chv[i] = int'($urandom_range(0, 65535)) - 32768;
        endcase
        gv[i] = int'($urandom_range(0, 255));
      end
      issue();
      step($urandom_range(0, CH + 2));
    end

    for (int t = 0; t < 50 && q.size() != 0; t++) step(1);
    check("drain_pending", longint'(q.size()), 0);
    check("final_overrun", longint'(overrun), longint'(exp_overrun));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
